// File: rtl/multdiv_unit_if.sv
// Handshake and data bundle between the execute stage and the iterative multiply/divide unit.
interface multdiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Fixed latency: one-cycle ready strobe WIDTH+1 edges after the start edge.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input logic          clock,
  input logic          reset,
  multdiv_unit_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastIt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Shared datapath: {hi[WIDTH:0], lo[WIDTH-1:0]} is the Booth product or {remainder, quotient}.
  logic [2*WIDTH:0] acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] abs_a, abs_b, q_mag, r_mag;
  logic [WIDTH:0]   hi_sum, r_sh, diff;

  always_comb begin
    abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    unique case ({acc_q[0], qm1_q})
      2'b01:   hi_sum = acc_q[2*WIDTH:WIDTH] + {m_q[WIDTH-1], m_q};
      2'b10:   hi_sum = acc_q[2*WIDTH:WIDTH] - {m_q[WIDTH-1], m_q};
      default: hi_sum = acc_q[2*WIDTH:WIDTH];
    endcase

    r_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff  = r_sh - {1'b0, m_q};
    q_mag = acc_q[WIDTH-1:0];
    r_mag = acc_q[2*WIDTH-1:WIDTH];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    rem_d    = rem_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle: begin
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          busy_d   = 1'b1;
          cnt_d    = '0;
          qm1_d    = 1'b0;
          is_div_d = ~bus.ctrl_MULT;
          sign_a_d = bus.data_operandA[WIDTH-1];
          sign_b_d = bus.data_operandB[WIDTH-1];
          if (bus.ctrl_MULT) begin
            state_d = StMul;
            m_d     = bus.data_operandA;
            acc_d   = {{(WIDTH+1){1'b0}}, bus.data_operandB};
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = StDiv;
            m_d     = abs_b;
            acc_d   = {{(WIDTH+1){1'b0}}, abs_a};
            dz_d    = (bus.data_operandB == '0);
            ovf_d   = (bus.data_operandA == MinVal) && (&bus.data_operandB);
          end
        end
      end
      StMul: begin
        acc_d = {hi_sum[WIDTH], hi_sum, acc_q[WIDTH-1:1]};
        qm1_d = acc_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIt) state_d = StFix;
      end
      StDiv: begin
        if (!diff[WIDTH]) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {r_sh, acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIt) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          result_d = acc_q[WIDTH-1:0];
          rem_d    = '0;
          // Product fits in WIDTH bits only if its top WIDTH+1 bits are a pure sign extension.
          exc_d    = ~((&acc_q[2*WIDTH-1:WIDTH-1]) | ~(|acc_q[2*WIDTH-1:WIDTH-1]));
        end else if (dz_q) begin
          result_d = '0;
          rem_d    = '0;
          exc_d    = 1'b1;
        end else begin
          result_d = (sign_a_q ^ sign_b_q) ? -q_mag : q_mag;
          rem_d    = sign_a_q ? -r_mag : r_mag;
          exc_d    = ovf_q;
        end
        rdy_d   = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
